// File: rtl/quadtree_route_unit_pkg.sv
// Shared packet-type codes, route-unit state encoding and address-field helper
// for the tree router input-port route unit.
package quadtree_route_unit_pkg;

  localparam int ROUTER_INFO_WIDTH = 4;

  localparam logic [ROUTER_INFO_WIDTH-1:0] ROUTER_INFO_CONFIG        = 4'd0;
  localparam logic [ROUTER_INFO_WIDTH-1:0] ROUTER_INFO_CALC          = 4'd1;
  localparam logic [ROUTER_INFO_WIDTH-1:0] ROUTER_INFO_BROADCAST     = 4'd2;
  localparam logic [ROUTER_INFO_WIDTH-1:0] ROUTER_INFO_FIN_BROADCAST = 4'd3;

  typedef enum logic [1:0] {
    RU_IDLE   = 2'd0,
    RU_ACTIVE = 2'd1,
    RU_DROP   = 2'd2
  } ru_state_e;

  // Right-shift that brings this level's child index down to bit 0.
  function automatic int ru_index_shift(int addr_w, int level, int cb);
    return addr_w - (level + 1) * cb;
  endfunction

endpackage

// File: rtl/quadtree_route_unit_if.sv
// Flit handshake between input buffer / switch allocator (master) and the
// route unit (slave).
interface quadtree_route_unit_if
  import quadtree_route_unit_pkg::*;
#(
  parameter int DIR        = 5,
  parameter int ADDR_WIDTH = 16,
  parameter int INFO_WIDTH = ROUTER_INFO_WIDTH
) ();

  logic                  in_valid;
  logic                  in_head;
  logic                  in_tail;
  logic [INFO_WIDTH-1:0] route_info;
  logic [ADDR_WIDTH-1:0] route_addr;
  logic                  in_pop;
  logic [DIR-1:0]        out_req;
  logic [DIR-1:0]        out_grant;

  modport master (
    output in_valid, in_head, in_tail, route_info, route_addr, out_grant,
    input  in_pop, out_req
  );

  modport slave (
    input  in_valid, in_head, in_tail, route_info, route_addr, out_grant,
    output in_pop, out_req
  );

endinterface

// File: rtl/quadtree_route_unit_route_decode.sv
// Combinational head-flit decoder: packet type + destination address to an
// output-port mask (children in the low bits, parent port in the top bit).
module quadtree_route_unit_route_decode
  import quadtree_route_unit_pkg::*;
#(
  parameter int NUM_CHILD  = 4,
  parameter int LEVEL_ID   = 0,
  parameter int ADDR_WIDTH = 16,
  parameter int INFO_WIDTH = ROUTER_INFO_WIDTH,
  parameter bit IS_LOCAL   = 1'b1
) (
  input  logic                  en,
  input  logic [INFO_WIDTH-1:0] route_info,
  input  logic [ADDR_WIDTH-1:0] route_addr,
  output logic [NUM_CHILD:0]    mask
);

  localparam int CB    = $clog2(NUM_CHILD);
  localparam int SHIFT = ru_index_shift(ADDR_WIDTH, LEVEL_ID, CB);

  logic [CB-1:0]        idx;
  logic [NUM_CHILD-1:0] child_oh;
  logic                 is_config, is_calc, is_bcast, is_fin;

  always_comb begin
    idx       = CB'(route_addr >> SHIFT);
    is_config = (route_info == INFO_WIDTH'(ROUTER_INFO_CONFIG));
    is_calc   = (route_info == INFO_WIDTH'(ROUTER_INFO_CALC));
    is_bcast  = (route_info == INFO_WIDTH'(ROUTER_INFO_BROADCAST));
    is_fin    = (route_info == INFO_WIDTH'(ROUTER_INFO_FIN_BROADCAST));

    // Indices beyond NUM_CHILD (non power-of-two fan-out) route nowhere.
    child_oh = '0;
    for (int c = 0; c < NUM_CHILD; c++) begin
      if (int'(idx) == c) child_oh[c] = 1'b1;
    end

    mask = '0;
    if (en) begin
      if (IS_LOCAL) begin
        if (is_config)                    mask[NUM_CHILD-1:0] = child_oh;
        else if (is_calc)                 mask[NUM_CHILD-1:0] = '1;
        else if (is_bcast && LEVEL_ID > 0) mask[NUM_CHILD-1:0] = '1;
      end else if (LEVEL_ID == 0) begin
        // At the root, up-traffic broadcasts turn around toward all children.
        if (is_bcast)    mask[NUM_CHILD-1:0] = '1;
        else if (is_fin) mask[NUM_CHILD]     = 1'b1;
      end else begin
        if (is_bcast || is_fin) mask[NUM_CHILD] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/quadtree_route_unit.sv
// Per-input-port route unit: locks a decoded route for a whole packet and
// retires each flit only after every routed output port has granted it.
module quadtree_route_unit
  import quadtree_route_unit_pkg::*;
#(
  parameter int NUM_CHILD  = 4,
  parameter int LEVEL_ID   = 0,
  parameter int ADDR_WIDTH = 16,
  parameter int INFO_WIDTH = ROUTER_INFO_WIDTH,
  parameter bit IS_LOCAL   = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  quadtree_route_unit_if.slave  bus,
  output logic [NUM_CHILD:0]    route_mask,
  output logic                  busy,
  output logic                  err_unroutable
);

  localparam int DIR = NUM_CHILD + 1;

  ru_state_e      state_q, state_d;
  logic [DIR-1:0] pending_q, pending_d;
  logic [DIR-1:0] route_mask_q, route_mask_d;
  logic           err_q, err_d;

  logic           dec_en;
  logic [DIR-1:0] dec_mask;
  logic [DIR-1:0] req;
  logic [DIR-1:0] remain;
  logic           pop;

  quadtree_route_unit_route_decode #(
    .NUM_CHILD  (NUM_CHILD),
    .LEVEL_ID   (LEVEL_ID),
    .ADDR_WIDTH (ADDR_WIDTH),
    .INFO_WIDTH (INFO_WIDTH),
    .IS_LOCAL   (IS_LOCAL)
  ) u_decode (
    .en         (dec_en),
    .route_info (bus.route_info),
    .route_addr (bus.route_addr),
    .mask       (dec_mask)
  );

  always_comb begin
    state_d      = state_q;
    pending_d    = pending_q;
    route_mask_d = route_mask_q;
    err_d        = err_q;
    dec_en       = 1'b0;
    req          = '0;
    remain       = '0;
    pop          = 1'b0;

    unique case (state_q)
      RU_IDLE: begin
        if (bus.in_valid) begin
          if (bus.in_head) begin
            dec_en = 1'b1;
            if (dec_mask != '0) begin
              route_mask_d = dec_mask;
              pending_d    = dec_mask;
              state_d      = RU_ACTIVE;
            end else begin
              err_d = 1'b1;
              pop   = 1'b1;
              if (!bus.in_tail) state_d = RU_DROP;
            end
          end else begin
            pop = 1'b1;
          end
        end
      end

      RU_ACTIVE: begin
        // Only grants on requested ports count; delivered ports stay cleared.
        req       = pending_q & {DIR{bus.in_valid}};
        remain    = pending_q & ~(bus.out_grant & req);
        pending_d = remain;
        if (bus.in_valid && remain == '0) begin
          pop = 1'b1;
          if (bus.in_tail) begin
            state_d      = RU_IDLE;
            route_mask_d = '0;
            pending_d    = '0;
          end else begin
            pending_d = route_mask_q;
          end
        end
      end

      RU_DROP: begin
        pop = bus.in_valid;
        if (bus.in_valid && bus.in_tail) state_d = RU_IDLE;
      end

      default: state_d = RU_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= RU_IDLE;
      pending_q    <= '0;
      route_mask_q <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      pending_q    <= pending_d;
      route_mask_q <= route_mask_d;
      err_q        <= err_d;
    end
  end

  assign bus.out_req     = req;
  assign bus.in_pop      = pop;
  assign route_mask      = route_mask_q;
  assign busy            = (state_q != RU_IDLE);
  assign err_unroutable  = err_q;

endmodule

// File: tb/tb_quadtree_route_unit.sv
// Four route units (different levels / directions) driven by one flit stream,
// checked every cycle against a packet-level model plus literal expectations.
module tb_quadtree_route_unit;
  import quadtree_route_unit_pkg::*;

  localparam int NI  = 4;
  localparam int DIR = 5;
  localparam int LVL_T [NI] = '{0, 1, 2, 0};
  localparam bit LOC_T [NI] = '{1'b1, 1'b1, 1'b0, 1'b0};

  logic        clk = 1'b0;
  logic        rst;
  logic        rst_v;
  logic        valid, head, tail;
  logic [3:0]  info;
  logic [15:0] addr;
  logic [4:0]  grant;

  logic [4:0]  req_a  [NI];
  logic [4:0]  mask_a [NI];
  logic        pop_a  [NI];
  logic        busy_a [NI];
  logic        err_a  [NI];

  int n_chk = 0;
  int n_err = 0;

  logic [4:0] m_mask [NI];
  logic [4:0] m_got  [NI];
  bit         m_lock [NI];
  bit         m_drop [NI];
  bit         m_err  [NI];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    quadtree_route_unit_if #(.DIR(DIR), .ADDR_WIDTH(16), .INFO_WIDTH(ROUTER_INFO_WIDTH)) bus ();
    assign bus.in_valid   = valid;
    assign bus.in_head    = head;
    assign bus.in_tail    = tail;
    assign bus.route_info = info;
    assign bus.route_addr = addr;
    assign bus.out_grant  = grant;
    assign req_a[g]       = bus.out_req;
    assign pop_a[g]       = bus.in_pop;

    quadtree_route_unit #(
      .NUM_CHILD  (4),
      .LEVEL_ID   (LVL_T[g]),
      .ADDR_WIDTH (16),
      .INFO_WIDTH (ROUTER_INFO_WIDTH),
      .IS_LOCAL   (LOC_T[g])
    ) u_dut (
      .clk            (clk),
      .rst            (rst),
      .bus            (bus),
      .route_mask     (mask_a[g]),
      .busy           (busy_a[g]),
      .err_unroutable (err_a[g])
    );
  end

  function automatic logic [4:0] model_route(int lvl, bit loc, logic [3:0] inf, logic [15:0] ad);
    int         idx;
    logic [4:0] r;
    idx = int'(ad >> (14 - 2 * lvl)) & 3;
    r   = 5'b0;
    if (loc) begin
      if (inf == ROUTER_INFO_CONFIG)                r = 5'(1 << idx);
      else if (inf == ROUTER_INFO_CALC)             r = 5'b01111;
      else if (inf == ROUTER_INFO_BROADCAST && lvl > 0) r = 5'b01111;
    end else begin
      if (inf == ROUTER_INFO_BROADCAST)          r = (lvl == 0) ? 5'b01111 : 5'b10000;
      else if (inf == ROUTER_INFO_FIN_BROADCAST) r = 5'b10000;
    end
    return r;
  endfunction

  task automatic chk(string nm, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_cycle();
    for (int i = 0; i < NI; i++) begin
      logic [4:0] e_req;
      logic [4:0] g_eff;
      logic [4:0] r;
      bit         e_pop;
      if (!rst) begin
        m_lock[i] = 1'b0; m_drop[i] = 1'b0; m_err[i] = 1'b0;
        m_mask[i] = 5'b0; m_got[i]  = 5'b0;
      end
      e_req = (m_lock[i] && valid) ? (m_mask[i] & ~m_got[i]) : 5'b0;
      g_eff = grant & e_req;
      r     = model_route(LVL_T[i], LOC_T[i], info, addr);
      if (m_lock[i])      e_pop = valid && ((m_got[i] | g_eff) == m_mask[i]);
      else if (m_drop[i]) e_pop = valid;
      else                e_pop = valid && (!head || r == 5'b0);

      chk($sformatf("u%0d out_req", i), int'(req_a[i]), int'(e_req));
      chk($sformatf("u%0d in_pop", i), int'(pop_a[i]), int'(e_pop));
      chk($sformatf("u%0d route_mask", i), int'(mask_a[i]), int'(m_mask[i]));
      chk($sformatf("u%0d busy", i), int'(busy_a[i]), int'(m_lock[i] || m_drop[i]));
      chk($sformatf("u%0d err", i), int'(err_a[i]), int'(m_err[i]));

      if (rst) begin
        if (m_lock[i]) begin
          if (valid) m_got[i] = m_got[i] | g_eff;
          if (e_pop) begin
            m_got[i] = 5'b0;
            if (tail) begin
              m_lock[i] = 1'b0;
              m_mask[i] = 5'b0;
            end
          end
        end else if (m_drop[i]) begin
          if (valid && tail) m_drop[i] = 1'b0;
        end else if (valid && head) begin
          if (r != 5'b0) begin
            m_lock[i] = 1'b1;
            m_mask[i] = r;
            m_got[i]  = 5'b0;
          end else begin
            m_err[i] = 1'b1;
            if (!tail) m_drop[i] = 1'b1;
          end
        end
      end
    end
  endtask

  task automatic step(bit v, bit h, bit t, logic [3:0] inf, logic [15:0] ad, logic [4:0] gr);
    @(posedge clk);
    #1;
    rst   = rst_v;
    valid = v;
    head  = h;
    tail  = t;
    info  = inf;
    addr  = ad;
    grant = gr;
    @(negedge clk);
    model_cycle();
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 4'd0, 16'h0000, 5'b0);
  endtask

  initial begin
    rst = 1'b0; rst_v = 1'b0;
    valid = 1'b0; head = 1'b0; tail = 1'b0;
    info = 4'd0; addr = 16'h0; grant = 5'b0;

    idle();
    idle();
    chk("reset busy", int'(busy_a[0]), 0);
    chk("reset out_req", int'(req_a[0]), 0);
    chk("reset route_mask", int'(mask_a[0]), 0);
    rst_v = 1'b1;
    idle();

    // T1: root, down-traffic CONFIG to child 2 (addr[15:14]=2)
    step(1, 1, 1, ROUTER_INFO_CONFIG, 16'h8000, 5'b0);
    chk("T1 c0 out_req", int'(req_a[0]), 0);
    chk("T1 c0 in_pop", int'(pop_a[0]), 0);
    step(1, 1, 1, ROUTER_INFO_CONFIG, 16'h8000, 5'b11111);
    chk("T1 c1 out_req", int'(req_a[0]), 5'b00100);
    chk("T1 c1 in_pop", int'(pop_a[0]), 1);
    chk("T1 c1 route_mask", int'(mask_a[0]), 5'b00100);
    idle();
    chk("T1 c2 busy", int'(busy_a[0]), 0);

    // T2: level 1, 3-flit CALC with split grants per flit
    step(1, 1, 0, ROUTER_INFO_CALC, 16'h0000, 5'b0);
    for (int f = 0; f < 3; f++) begin
      step(1, f == 0, f == 2, ROUTER_INFO_CALC, 16'h0000, 5'b00011);
      chk($sformatf("T2 f%0d first out_req", f), int'(req_a[1]), 5'b01111);
      chk($sformatf("T2 f%0d first in_pop", f), int'(pop_a[1]), 0);
      step(1, f == 0, f == 2, ROUTER_INFO_CALC, 16'h0000, 5'b01100);
      chk($sformatf("T2 f%0d second out_req", f), int'(req_a[1]), 5'b01100);
      chk($sformatf("T2 f%0d second in_pop", f), int'(pop_a[1]), 1);
    end
    idle();
    chk("T2 end busy", int'(busy_a[1]), 0);

    // T5: root down-traffic BROADCAST is unroutable; next CALC still routes
    step(1, 1, 0, ROUTER_INFO_BROADCAST, 16'h0000, 5'b0);
    chk("T5 head in_pop", int'(pop_a[0]), 1);
    chk("T5 head out_req", int'(req_a[0]), 0);
    chk("T5 head err before", int'(err_a[0]), 0);
    step(1, 0, 1, ROUTER_INFO_BROADCAST, 16'h0000, 5'b0);
    chk("T5 tail in_pop", int'(pop_a[0]), 1);
    chk("T5 tail err", int'(err_a[0]), 1);
    chk("T5 tail busy", int'(busy_a[0]), 1);
    step(1, 1, 1, ROUTER_INFO_CALC, 16'h0000, 5'b0);
    chk("T5 calc c0 busy", int'(busy_a[0]), 0);
    step(1, 1, 1, ROUTER_INFO_CALC, 16'h0000, 5'b11111);
    chk("T5 calc out_req", int'(req_a[0]), 5'b01111);
    chk("T5 calc in_pop", int'(pop_a[0]), 1);
    idle();
    chk("T5 err sticky", int'(err_a[0]), 1);

    // T3: level 2, up-traffic FIN_BROADCAST waits on parent grant
    step(1, 1, 1, ROUTER_INFO_FIN_BROADCAST, 16'h0000, 5'b0);
    for (int c = 0; c < 5; c++) begin
      step(1, 1, 1, ROUTER_INFO_FIN_BROADCAST, 16'h0000, 5'b0);
      chk($sformatf("T3 wait%0d out_req", c), int'(req_a[2]), 5'b10000);
      chk($sformatf("T3 wait%0d in_pop", c), int'(pop_a[2]), 0);
    end
    step(1, 1, 1, ROUTER_INFO_FIN_BROADCAST, 16'h0000, 5'b10000);
    chk("T3 grant out_req", int'(req_a[2]), 5'b10000);
    chk("T3 grant in_pop", int'(pop_a[2]), 1);
    idle();
    chk("T3 end busy", int'(busy_a[2]), 0);

    // T4: root, up-traffic 4-flit BROADCAST; address/info change mid-packet
    step(1, 1, 0, ROUTER_INFO_BROADCAST, 16'h0000, 5'b11111);
    chk("T4 c0 in_pop", int'(pop_a[3]), 0);
    for (int f = 0; f < 4; f++) begin
      if (f == 0) step(1, 1, 0, ROUTER_INFO_BROADCAST, 16'h0000, 5'b11111);
      else        step(1, 0, f == 3, ROUTER_INFO_CONFIG, 16'hFFFF, 5'b11111);
      chk($sformatf("T4 f%0d in_pop", f), int'(pop_a[3]), 1);
      chk($sformatf("T4 f%0d out_req", f), int'(req_a[3]), 5'b01111);
      chk($sformatf("T4 f%0d route_mask", f), int'(mask_a[3]), 5'b01111);
    end
    idle();
    chk("T4 end busy", int'(busy_a[3]), 0);
    chk("T4 end route_mask", int'(mask_a[3]), 0);

    // T6: reset while ACTIVE with pending 01010, then trailing flit is a stray
    step(1, 1, 0, ROUTER_INFO_CALC, 16'h0000, 5'b0);
    step(1, 1, 0, ROUTER_INFO_CALC, 16'h0000, 5'b00101);
    chk("T6 partial in_pop", int'(pop_a[0]), 0);
    step(1, 1, 0, ROUTER_INFO_CALC, 16'h0000, 5'b0);
    chk("T6 pending out_req", int'(req_a[0]), 5'b01010);
    rst_v = 1'b0;
    idle();
    chk("T6 rst out_req", int'(req_a[0]), 0);
    chk("T6 rst busy", int'(busy_a[0]), 0);
    chk("T6 rst route_mask", int'(mask_a[0]), 0);
    chk("T6 rst err", int'(err_a[0]), 0);
    rst_v = 1'b1;
    idle();
    step(1, 0, 1, ROUTER_INFO_CALC, 16'h0000, 5'b11111);
    chk("T6 stray in_pop", int'(pop_a[0]), 1);
    chk("T6 stray out_req", int'(req_a[0]), 0);
    idle();
    chk("T6 end busy", int'(busy_a[0]), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
